layer_gate_sequencer: RTL and testbench



---
 rtl/layer_seq_pkg.sv | 12 +
 rtl/layer_input_mux.sv | 19 +
 rtl/layer_gate_sequencer.sv | 158 +++++++++++++++
 tb/tb_layer_gate_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_seq_pkg.sv
// Shared types and defaults for the layer gate sequencer.
package layer_seq_pkg;

  localparam int unsigned NBITS_DEFAULT = 61;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/layer_input_mux.sv
// Selects one field element out of the packed layer input vector.
module layer_input_mux #(
  parameter int unsigned ninputs = 8,
  parameter int unsigned nbits   = 61,
  parameter int unsigned ninbits = $clog2(ninputs)
) (
  input  logic [ninputs*nbits-1:0] v_in,
  input  logic [ninbits-1:0]       sel,
  output logic [nbits-1:0]         y
);

  always_comb begin
    y = '0;
    for (int k = 0; k < int'(ninputs); k++) begin
      if (sel == ninbits'(k)) y = v_in[k*nbits +: nbits];
    end
  end

endmodule

// File: rtl/layer_gate_sequencer.sv
// Walks the gates of one circuit layer, issuing one add/mul per gate to a
// shared arithmetic unit and collecting the results into v_out.
module layer_gate_sequencer
  import layer_seq_pkg::*;
#(
  parameter int unsigned               ngates    = 8,
  parameter int unsigned               ninputs   = 8,
  parameter int unsigned               nbits     = NBITS_DEFAULT,
  parameter logic [ngates-1:0]         gates_mul = '0,
  parameter int unsigned               ninbits   = $clog2(ninputs),
  parameter logic [ninbits*ngates-1:0] gates_in0 = '0,
  parameter logic [ninbits*ngates-1:0] gates_in1 = '0
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       en,
  input  logic [ninputs*nbits-1:0]   v_in,
  output logic [ngates*nbits-1:0]    v_out,
  output logic                       ready,
  output logic                       op_en,
  output logic                       op_mul,
  output logic [nbits-1:0]           op_a,
  output logic [nbits-1:0]           op_b,
  input  logic                       op_ready,
  input  logic [nbits-1:0]           op_result,
  output logic [$clog2(ngates):0]    gate_idx
);

  localparam int unsigned GW = $clog2(ngates) + 1;

  // Bad configurations reference a module that does not exist.
  if (ngates < 1 || ninputs < 2) begin : g_bad_size
    layer_gate_sequencer_bad_size u_bad ();
  end
  for (genvar g = 0; g < int'(ngates); g++) begin : g_chk
    if (32'(gates_in0[g*ninbits +: ninbits]) >= ninputs ||
        32'(gates_in1[g*ninbits +: ninbits]) >= ninputs) begin : g_bad_idx
      layer_gate_sequencer_bad_index u_bad ();
    end
  end

  state_e                  state_q, state_d;
  logic [GW-1:0]           gate_idx_q, gate_idx_d;
  logic                    ready_q, ready_d;
  logic                    op_en_q, op_en_d;
  logic                    op_mul_q, op_mul_d;
  logic [nbits-1:0]        op_a_q, op_a_d, op_b_q, op_b_d;
  logic [ngates*nbits-1:0] v_out_q, v_out_d;
  logic [nbits-1:0]        sel_a, sel_b;
  logic [ninbits-1:0]      in0_idx, in1_idx;
  logic                    cfg_mul;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    gate_idx_d = gate_idx_q;
    ready_d    = ready_q;
    op_en_d    = 1'b0;
    v_out_d    = v_out_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d    = ISSUE;
          gate_idx_d = '0;
          ready_d    = 1'b0;
          op_en_d    = 1'b1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (op_ready) begin
          for (int g = 0; g < int'(ngates); g++) begin
            if (gate_idx_q == GW'(g)) v_out_d[g*nbits +: nbits] = op_result;
          end
          if (gate_idx_q == GW'(ngates - 1)) begin
            state_d = IDLE;
            ready_d = 1'b1;
          end else begin
            state_d    = ISSUE;
            gate_idx_d = gate_idx_q + GW'(1);
            op_en_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands are decoded for the gate about to be issued so they register alongside op_en.
  always_comb begin
    in0_idx = '0;
    in1_idx = '0;
    cfg_mul = 1'b0;
    for (int g = 0; g < int'(ngates); g++) begin
      if (gate_idx_d == GW'(g)) begin
        in0_idx = gates_in0[g*ninbits +: ninbits];
        in1_idx = gates_in1[g*ninbits +: ninbits];
        cfg_mul = gates_mul[g];
      end
    end
  end

  layer_input_mux #(.ninputs(ninputs), .nbits(nbits), .ninbits(ninbits)) u_mux_a (
    .v_in (v_in),
    .sel  (in0_idx),
    .y    (sel_a)
  );

  layer_input_mux #(.ninputs(ninputs), .nbits(nbits), .ninbits(ninbits)) u_mux_b (
    .v_in (v_in),
    .sel  (in1_idx),
    .y    (sel_b)
  );

  always_comb begin
    op_mul_d = op_mul_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    if (op_en_d) begin
      op_mul_d = cfg_mul;
      op_a_d   = sel_a;
      op_b_d   = sel_b;
    end
  end

  // NOTE: non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= IDLE;
      gate_idx_q <= '0;
      ready_q    <= 1'b1;
      op_en_q    <= 1'b0;
      op_mul_q   <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      // NOTE: the result bank is reset because a reset must visibly discard partial results.
      v_out_q    <= '0;
    end else begin
      state_q    <= state_d;
      gate_idx_q <= gate_idx_d;
      ready_q    <= ready_d;
      op_en_q    <= op_en_d;
      op_mul_q   <= op_mul_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      v_out_q    <= v_out_d;
    end
  end

  assign v_out    = v_out_q;
  assign ready    = ready_q;
  assign op_en    = op_en_q;
  assign op_mul   = op_mul_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign gate_idx = gate_idx_q;

endmodule

// File: tb/tb_layer_gate_sequencer.sv
// Scoreboard bench: stimulus queues expected ops/results, a monitor checks them.
module tb_layer_gate_sequencer;

  localparam logic [7:0]  GMUL = 8'ha5;
  localparam logic [23:0] GIN0 = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [23:0] GIN1 = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  localparam logic [63:0] VIN  = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [63:0] EXP_VOUT = {8'd8, 8'd9, 8'd18, 8'd9, 8'd9, 8'd18, 8'd9, 8'd8};
  localparam bit          MUL_T [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  localparam logic [7:0]  A_T   [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
  localparam logic [7:0]  B_T   [8] = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};

  typedef struct { logic mul; logic [7:0] a; logic [7:0] b; int cyc; } op_t;
  typedef struct { logic [63:0] v; int cyc; } done_t;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        en = 1'b0;
  logic [63:0] v_in = VIN;
  logic [63:0] v_out;
  logic        ready, op_en, op_mul, op_ready;
  logic [7:0]  op_a, op_b, op_result;
  logic [3:0]  gate_idx;

  logic        model_rdy = 1'b0;
  logic [7:0]  model_res = '0;
  logic        spur_rdy = 1'b0;
  int          lat_max = 1;

  logic        en2 = 1'b0;
  logic [15:0] v_in2 = {8'd5, 8'd3};
  logic [7:0]  v_out2, op_a2, op_b2, op_result2;
  logic        ready2, op_en2, op_mul2;
  logic        op_ready2 = 1'b0;
  logic [0:0]  gate_idx2;

  int    cyc = 0;
  int    n_checks = 0;
  int    n_err = 0;
  int    last_rdy = 0;
  op_t   exp_ops[$];
  done_t exp_done[$];

  assign op_ready  = model_rdy | spur_rdy;
  assign op_result = model_rdy ? model_res : 8'hEE;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  layer_gate_sequencer #(
    .ngates(8), .ninputs(8), .nbits(8), .gates_mul(GMUL), .ninbits(3),
    .gates_in0(GIN0), .gates_in1(GIN1)
  ) dut (
    .clk(clk), .rstb(rstb), .en(en), .v_in(v_in), .v_out(v_out), .ready(ready),
    .op_en(op_en), .op_mul(op_mul), .op_a(op_a), .op_b(op_b),
    .op_ready(op_ready), .op_result(op_result), .gate_idx(gate_idx)
  );

  layer_gate_sequencer #(
    .ngates(1), .ninputs(2), .nbits(8), .gates_mul(1'b1), .ninbits(1),
    .gates_in0(1'b0), .gates_in1(1'b1)
  ) dut2 (
    .clk(clk), .rstb(rstb), .en(en2), .v_in(v_in2), .v_out(v_out2), .ready(ready2),
    .op_en(op_en2), .op_mul(op_mul2), .op_a(op_a2), .op_b(op_b2),
    .op_ready(op_ready2), .op_result(op_result2), .gate_idx(gate_idx2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Arithmetic unit model: latency 1..lat_max, 8-bit truncating add/mul.
  initial begin
    logic       m;
    logic [7:0] a, b;
    int         l;
    forever begin
      @(negedge clk);
      if (op_en && rstb) begin
        m = op_mul; a = op_a; b = op_b;
        l = $urandom_range(lat_max, 1);
        repeat (l) @(posedge clk);
        #1;
        model_res = m ? a * b : a + b;
        model_rdy = 1'b1;
        @(posedge clk);
        #1 model_rdy = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (op_en2) begin
        op_result2 = op_mul2 ? op_a2 * op_b2 : op_a2 + op_b2;
        @(posedge clk);
        #1 op_ready2 = 1'b1;
        @(posedge clk);
        #1 op_ready2 = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every op_en and on every rise of ready.
  initial begin
    op_t   e;
    done_t d;
    logic  ready_prev;
    ready_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rstb) begin
        ready_prev = ready;
        continue;
      end
      if (op_en) begin
        if (exp_ops.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_op_en: op_en=1 at cycle %0d, expected 0", cyc);
        end else begin
          e = exp_ops.pop_front();
          check("op_mul", 64'(op_mul), 64'(e.mul));
          check("op_a", 64'(op_a), 64'(e.a));
          check("op_b", 64'(op_b), 64'(e.b));
          if (e.cyc >= 0) check("op_en_cycle", 64'(cyc), 64'(e.cyc));
          if (gate_idx != 4'd0) check("op_gap", 64'(cyc), 64'(last_rdy + 1));
        end
      end
      if (ready && !ready_prev) begin
        if (exp_done.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_done: ready rose at cycle %0d, expected no completion", cyc);
        end else begin
          d = exp_done.pop_front();
          check("v_out", v_out, d.v);
          if (d.cyc >= 0) check("ready_cycle", 64'(cyc), 64'(d.cyc));
        end
      end
      if (model_rdy) last_rdy = cyc;
      ready_prev = ready;
    end
  end

  task automatic run_eval(input bit timed);
    int c0;
    @(negedge clk);
    c0 = cyc;
    for (int g = 0; g < 8; g++)
      exp_ops.push_back('{MUL_T[g], A_T[g], B_T[g], timed ? c0 + 1 + 2 * g : -1});
    exp_done.push_back('{EXP_VOUT, timed ? c0 + 17 : -1});
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (exp_done.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (exp_done.size() != 0) begin
      n_checks++; n_err++;
      $display("FAIL done_timeout: %0d completions pending, expected 0", exp_done.size());
      exp_done.delete();
    end
    check("ops_consumed", 64'(exp_ops.size()), 64'd0);
    exp_ops.delete();
  endtask

  task automatic wait_gate(input logic [3:0] g, input bit need_op_en);
    int n = 0;
    while (!(gate_idx == g && (op_en || !need_op_en)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_checks++; n_err++;
      $display("FAIL gate_wait_timeout: gate_idx=%0d, expected %0d", gate_idx, g);
    end
  endtask

  initial begin
    int c0, n;

    // Reset values
    #12;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_op_en", 64'(op_en), 64'd0);
    check("rst_op_mul", 64'(op_mul), 64'd0);
    check("rst_op_a", 64'(op_a), 64'd0);
    check("rst_op_b", 64'(op_b), 64'd0);
    check("rst_v_out", v_out, 64'd0);
    check("rst_gate_idx", 64'(gate_idx), 64'd0);
    @(posedge clk);
    #2 rstb = 1'b1;

    // Basic evaluation, L=1, exact timing
    run_eval(1'b1);
    wait_done(100);

    // Variable latency
    lat_max = 5;
    run_eval(1'b0);
    wait_done(400);
    lat_max = 1;

    // Spurious op_ready while idle
    @(negedge clk);
    spur_rdy = 1'b1;
    @(negedge clk);
    spur_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_spur_v_out", v_out, EXP_VOUT);
    check("idle_spur_ready", 64'(ready), 64'd1);

    // op_ready coincident with op_en and en while busy must be ignored
    run_eval(1'b1);
    wait_gate(4'd2, 1'b1);
    spur_rdy = 1'b1;
    @(posedge clk);
    #1 spur_rdy = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_done(100);

    // Reset after gate 3 completes
    run_eval(1'b1);
    wait_gate(4'd4, 1'b1);
    @(posedge clk);
    #2 rstb = 1'b0;
    #1;
    check("midrst_v_out", v_out, 64'd0);
    check("midrst_ready", 64'(ready), 64'd1);
    check("midrst_op_en", 64'(op_en), 64'd0);
    check("midrst_gate_idx", 64'(gate_idx), 64'd0);
    exp_ops.delete();
    exp_done.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rstb = 1'b1;
    run_eval(1'b1);
    wait_done(100);

    // Single mul gate, two inputs
    @(negedge clk);
    c0 = cyc;
    en2 = 1'b1;
    @(negedge clk);
    en2 = 1'b0;
    n = 0;
    while (!ready2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("dut2_v_out", 64'(v_out2), 64'd15);
    check("dut2_ready_cycle", 64'(cyc), 64'(c0 + 3));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
